// File: rtl/bsram_read_arbiter_if.sv
// bsram_read_arbiter_if: requester, write and bsram-side signals of the read arbiter
interface bsram_read_arbiter_if #(parameter int WIDTH = 13);
  logic a_req;
  logic [WIDTH-1:0] a_addr;
  logic a_gnt;
  logic a_rvalid;
  logic [15:0] a_rdata;
  logic b_req;
  logic [WIDTH-1:0] b_addr;
  logic b_gnt;
  logic b_rvalid;
  logic [15:0] b_rdata;
  logic wr_en;
  logic [WIDTH-1:0] wr_addr;
  logic [15:0] wr_data;
  logic [WIDTH-1:0] mem_dout_addr;
  logic [15:0] mem_dout;
  logic mem_we;
  logic [WIDTH-1:0] mem_din_addr;
  logic [15:0] mem_din;
  modport slave (
    input a_req, a_addr, b_req, b_addr, wr_en, wr_addr, wr_data, mem_dout,
    output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
    output mem_dout_addr, mem_we, mem_din_addr, mem_din
  );
  modport master (
    output a_req, a_addr, b_req, b_addr, wr_en, wr_addr, wr_data, mem_dout,
    input a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
    input mem_dout_addr, mem_we, mem_din_addr, mem_din
  );
endinterface

// File: rtl/bsram_read_arbiter.sv
// bsram_read_arbiter: shares one bsram read port between CPU (A) and video (B), forwards the write port.
// Define BSRAM_ARB_RAW_BYPASS_EN for write-first data on same-cycle same-address read/write.
module bsram_read_arbiter #(
  parameter int WIDTH = 13,
  parameter int MAX_WAIT = 4
) (
  input logic clk,
  input logic reset,
  bsram_read_arbiter_if.slave bus
);
  typedef enum logic [1:0] {NONE, OWN_A, OWN_B} owner_t;
  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);
  owner_t owner, owner_nx;
  logic [3:0] wait_cnt, wait_nx;
  logic [WIDTH-1:0] last_addr, rd_addr;
  logic [15:0] a_hold, b_hold, rd_src;
  logic a_gnt, b_gnt;
  // B is real-time and normally wins; A is promoted once it has lost MAX_WAIT cycles in a row
  always_comb begin
    a_gnt = !reset && bus.a_req && (!bus.b_req || wait_cnt >= MAX_W);
    b_gnt = !reset && bus.b_req && !a_gnt;
    rd_addr = a_gnt ? bus.a_addr : b_gnt ? bus.b_addr : last_addr;
    owner_nx = a_gnt ? OWN_A : b_gnt ? OWN_B : NONE;
    wait_nx = (bus.a_req && !a_gnt) ? ((wait_cnt == MAX_W) ? wait_cnt : wait_cnt + 4'd1) : 4'd0;
    bus.a_gnt = a_gnt;
    bus.b_gnt = b_gnt;
    bus.mem_dout_addr = rd_addr;
    bus.a_rvalid = owner == OWN_A;
    bus.b_rvalid = owner == OWN_B;
    bus.a_rdata = (owner == OWN_A) ? rd_src : a_hold;
    bus.b_rdata = (owner == OWN_B) ? rd_src : b_hold;
    bus.mem_we = bus.wr_en && !reset;
    bus.mem_din_addr = bus.wr_addr;
    bus.mem_din = bus.wr_data;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner <= NONE;
      wait_cnt <= '0;
      last_addr <= '0;
      a_hold <= '0;
      b_hold <= '0;
    end else begin
      owner <= owner_nx;
      wait_cnt <= wait_nx;
      last_addr <= rd_addr;
      a_hold <= bus.a_rdata;
      b_hold <= bus.b_rdata;
    end
  end
`ifdef BSRAM_ARB_RAW_BYPASS_EN
  logic byp;
  logic [15:0] byp_data;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byp <= 1'b0;
      byp_data <= '0;
    end else begin
      byp <= (a_gnt || b_gnt) && bus.wr_en && bus.wr_addr == rd_addr;
      byp_data <= bus.wr_data;
    end
  end
  assign rd_src = byp ? byp_data : bus.mem_dout;
`else
  assign rd_src = bus.mem_dout;
`endif
endmodule

// File: tb/tb_bsram_read_arbiter.sv
// tb_bsram_read_arbiter: directed checks of arbitration, latency, hold, write path and reset
module tb_bsram_read_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int failed = 0;
  logic [15:0] mem [0:8191];
  bsram_read_arbiter_if #(.WIDTH(13)) bus ();
  bsram_read_arbiter #(.WIDTH(13), .MAX_WAIT(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    bus.mem_dout <= mem[bus.mem_dout_addr];
    if (bus.mem_we) mem[bus.mem_din_addr] <= bus.mem_din;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [12:0] ad, input logic [15:0] d);
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.wr_addr = ad;
    bus.wr_data = d;
  endtask
  task automatic tick();
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask
  initial begin
    bus.a_req = 1'b1; bus.a_addr = 13'd3;
    bus.b_req = 1'b1; bus.b_addr = 13'd4;
    bus.wr_en = 1'b1; bus.wr_addr = 13'd7; bus.wr_data = 16'h0;
    bus.mem_dout = 16'h0;
    #1;
    chk("rst_a_gnt", bus.a_gnt, 0);
    chk("rst_b_gnt", bus.b_gnt, 0);
    chk("rst_a_rvalid", bus.a_rvalid, 0);
    chk("rst_b_rvalid", bus.b_rvalid, 0);
    chk("rst_a_rdata", bus.a_rdata, 0);
    chk("rst_rd_addr", bus.mem_dout_addr, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    @(negedge clk);
    bus.a_req = 1'b0; bus.b_req = 1'b0; bus.wr_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    wr(13'd5, 16'h1234);
    #1 chk("we_fwd", bus.mem_we, 1);
    chk("din_fwd", bus.mem_din, 16'h1234);
    chk("din_addr_fwd", bus.mem_din_addr, 5);
    wr(13'd1, 16'h0011);
    wr(13'd2, 16'h0022);
    tick();
    // single read
    tick(); bus.a_req = 1'b1; bus.a_addr = 13'd5;
    #1 chk("single_gnt", bus.a_gnt, 1);
    chk("single_addr", bus.mem_dout_addr, 5);
    tick(); bus.a_req = 1'b0;
    #1 chk("single_rvalid", bus.a_rvalid, 1);
    chk("single_rdata", bus.a_rdata, 16'h1234);
    chk("single_gnt_off", bus.a_gnt, 0);
    chk("hold_addr", bus.mem_dout_addr, 5);
    tick();
    #1 chk("single_rvalid_off", bus.a_rvalid, 0);
    tick();
    #1 chk("single_hold", bus.a_rdata, 16'h1234);
    // contention
    tick(); bus.a_req = 1'b1; bus.a_addr = 13'd1; bus.b_req = 1'b1; bus.b_addr = 13'd2;
    #1 chk("cont_b_gnt", bus.b_gnt, 1);
    chk("cont_a_lose", bus.a_gnt, 0);
    tick(); bus.b_req = 1'b0;
    #1 chk("cont_a_gnt", bus.a_gnt, 1);
    chk("cont_b_rvalid", bus.b_rvalid, 1);
    chk("cont_b_rdata", bus.b_rdata, 16'h0022);
    tick(); bus.a_req = 1'b0;
    #1 chk("cont_a_rvalid", bus.a_rvalid, 1);
    chk("cont_a_rdata", bus.a_rdata, 16'h0011);
    chk("cont_b_hold", bus.b_rdata, 16'h0022);
    // starvation
    tick(); bus.a_req = 1'b1; bus.b_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("starve_a_%0d", i), bus.a_gnt, 0);
      chk($sformatf("starve_b_%0d", i), bus.b_gnt, 1);
      tick();
    end
    #1 chk("starve_a_win", bus.a_gnt, 1);
    chk("starve_b_lose", bus.b_gnt, 0);
    chk("starve_addr", bus.mem_dout_addr, 1);
    tick(); bus.a_req = 1'b0;
    #1 chk("starve_b_back", bus.b_gnt, 1);
    chk("starve_a_rdata", bus.a_rdata, 16'h0011);
    tick(); bus.a_req = 1'b1;
    #1 chk("starve_cnt_clr", bus.a_gnt, 0);
    tick(); bus.a_req = 1'b0; bus.b_req = 1'b0;
    // streaming
    for (int i = 0; i < 8; i++) wr(13'(i), 16'h00C0 + 16'(i));
    tick();
    for (int i = 0; i < 10; i++) begin
      tick(); bus.b_req = i < 8; bus.b_addr = 13'(i);
      #1 if (i < 8) chk($sformatf("stream_gnt_%0d", i), bus.b_gnt, 1);
      if (i >= 1 && i <= 8) begin
        chk($sformatf("stream_rvalid_%0d", i), bus.b_rvalid, 1);
        chk($sformatf("stream_rdata_%0d", i), bus.b_rdata, 16'h00C0 + 16'(i - 1));
      end
      if (i == 9) chk("stream_end", bus.b_rvalid, 0);
    end
    // read during write
    wr(13'd9, 16'hAAAA);
    tick();
    wr(13'd9, 16'h5555); bus.a_req = 1'b1; bus.a_addr = 13'd9;
    #1 chk("rdw_gnt", bus.a_gnt, 1);
    tick();
    #1 chk("rdw_rvalid", bus.a_rvalid, 1);
`ifdef BSRAM_ARB_RAW_BYPASS_EN
    chk("rdw_rdata", bus.a_rdata, 16'h5555);
`else
    chk("rdw_rdata", bus.a_rdata, 16'hAAAA);
`endif
    tick(); bus.a_req = 1'b0;
    #1 chk("rdw_next", bus.a_rdata, 16'h5555);
    // reset during an outstanding read
    tick(); bus.a_req = 1'b1; bus.a_addr = 13'd5;
    #1 chk("mid_gnt", bus.a_gnt, 1);
    @(posedge clk); #2;
    chk("mid_rvalid_pre", bus.a_rvalid, 1);
    reset = 1'b1;
    #1 chk("mid_rvalid_rst", bus.a_rvalid, 0);
    chk("mid_rdata_rst", bus.a_rdata, 0);
    chk("mid_gnt_rst", bus.a_gnt, 0);
    tick(); bus.a_req = 1'b0;
    tick(); reset = 1'b0;
    tick();
    #1 chk("mid_no_ghost", bus.a_rvalid, 0);
    chk("mid_rdata_zero", bus.a_rdata, 0);
    tick(); bus.a_req = 1'b1;
    #1 chk("post_gnt", bus.a_gnt, 1);
    tick(); bus.a_req = 1'b0;
    #1 chk("post_rvalid", bus.a_rvalid, 1);
    chk("post_rdata", bus.a_rdata, 16'h00C5);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/bsram_read_arbiter.md
Name: bsram_read_arbiter

Overview:
- Shares the single synchronous read port of one bsram instance between two requesters:
  - Port A: CPU data path, latency-tolerant.
  - Port B: video/GPU fetch, real-time.
- Forwards the single CPU write port to the bsram unchanged.
- Returns read data with a 1-cycle registered-memory latency plus per-port data hold.
- Sits between the CPU/GPU and the game-data bsram.

Parameters:
- WIDTH, 13: address width; matches the bsram WIDTH.
- MAX_WAIT, 4: number of consecutive lost arbitration cycles after which port A takes priority (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- a_req  in  1  port A read request.
- a_addr  in  WIDTH  port A read address.
- a_gnt  out  1  port A request accepted this cycle (combinational).
- a_rvalid  out  1  port A read data valid.
- a_rdata  out  16  port A read data.
- b_req  in  1  port B read request.
- b_addr  in  WIDTH  port B read address.
- b_gnt  out  1  port B request accepted this cycle (combinational).
- b_rvalid  out  1  port B read data valid.
- b_rdata  out  16  port B read data.
- wr_en  in  1  CPU write enable.
- wr_addr  in  WIDTH  CPU write address.
- wr_data  in  16  CPU write data.
- mem_dout_addr  out  WIDTH  to bsram read address.
- mem_dout  in  16  from bsram, registered read data.
- mem_we  out  1  to bsram we.
- mem_din_addr  out  WIDTH  to bsram write address.
- mem_din  out  16  to bsram write data.

Behaviour:
- Grant, per cycle, at most one of a_gnt / b_gnt is high:
  - Only one requester: it is granted.
  - Both requesting: B wins, unless wait_cnt >= MAX_WAIT, in which case A wins.
  - No request: neither granted.
- Request handshake: a request is consumed in the cycle its gnt is high. The requester holds req/addr until gnt; the arbiter never drops a pending request.
- mem_dout_addr equals the granted port's address. With no grant it holds the last granted address (0 after reset).
- wait_cnt, 4-bit saturating register:
  - Increments when a_req && !a_gnt.
  - Clears when a_gnt or !a_req.
  - Saturates at MAX_WAIT.
- Read owner register owner[1:0] (NONE/A/B), updated every cycle to the grant result.
- x_rvalid = (owner == X), asserted exactly 1 cycle after x_gnt.
- Read data:
  - x_rdata = mem_dout while x_rvalid.
  - Otherwise x_rdata = last value delivered to that port, held in a per-port 16-bit register updated on x_rvalid.
- Throughput: one read per cycle total. Back-to-back grants to the same or alternating ports are allowed with no bubbles.
- Write path:
  - mem_we = wr_en && !reset; mem_din_addr = wr_addr; mem_din = wr_data; all combinational.
  - Writes are never stalled and are not arbitrated.
- Read-during-write at the same address, default build: the read returns the old memory contents (read-first bsram behaviour).
- Reset, asynchronous:
  - Clears owner to NONE, wait_cnt to 0, both hold registers to 0, and last address to 0.
  - All rvalid outputs go low immediately; rdata outputs read 0.
  - Grants are combinational but forced low while reset is high.
- Reset during an outstanding read (owner != NONE): the data is discarded and no rvalid is produced after reset release.
- FSM: none beyond the owner register. The priority state is wait_cnt.

Optional Feature:
- Macro: BSRAM_ARB_RAW_BYPASS_EN.
- Defined:
  - If a read is granted in the same cycle as wr_en with wr_addr == granted address, register a bypass flag and wr_data.
  - On the following rvalid cycle, rdata returns the registered wr_data instead of mem_dout, giving write-first semantics.
  - Adds 17 flops; latency is unchanged.
- Undefined: no bypass logic; same-cycle same-address reads return old data.

Test Plan:
- Single read: mem[5]=0x1234; a_req=1, a_addr=5 for 1 cycle -> a_gnt=1 in cycle 0, a_rvalid=1 and a_rdata=0x1234 in cycle 1; a_rdata still 0x1234 in cycle 3.
- Contention: a_req and b_req both high with addrs 1 and 2 (mem 0x11/0x22) -> b_gnt cycle 0, a_gnt cycle 1; b_rvalid/0x22 at cycle 1, a_rvalid/0x11 at cycle 2.
- Starvation, MAX_WAIT=4: b_req held high, a_req raised at cycle 0 -> a_gnt first high at cycle 4; b_gnt low at cycle 4, high again at cycle 5; wait_cnt back to 0.
- Streaming: b_req high for 8 cycles, addrs 0..7 -> b_rvalid high 8 consecutive cycles, data in address order, no gaps.
- Read-during-write: mem[9]=0xAAAA; wr_en=1, wr_addr=9, wr_data=0x5555 and a read of 9 in the same cycle -> rdata 0xAAAA without the macro, 0x5555 with BSRAM_ARB_RAW_BYPASS_EN. A read of 9 the next cycle returns 0x5555 in both builds.
- Reset mid-read: grant A, assert reset before the next edge -> a_rvalid stays 0, a_rdata=0. After release, a new read works normally.
